// File: rtl/radix_2_ctrl.sv
// radix_2_ctrl: sequencing controller for an in-place iterative N-point
// NTT/INTT (N = 1 << n_log) wrapped around a combinational radix-2 butterfly.
// Each stage it reads one butterfly pair per cycle and presents the matching
// twiddle index. It then registers the butterfly results and writes them
// back to the same pair two cycles after the read.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, mode            launch a transform (sampled in IDLE); 0 = NTT, 1 = INTT
//   busy, done, stage      status: RUN/DRAIN, one-cycle completion pulse, stage index
//   bf_select              latched mode, drives the butterfly select input
//   rd_en, rd_addr_1/2     pair read strobe and addresses (memory has 1-cycle latency)
//   tw_idx                 twiddle ROM index aligned with rd_addr
//   bf_out_1/2             butterfly results, valid the cycle after rd_en
//   wr_en, wr_addr_1/2     write strobe and addresses (read addresses delayed 2 cycles)
//   wr_data_1/2            registered butterfly results
//
// state    | meaning
// st_idle  | waiting for start
// st_run   | issuing one pair read per cycle, p = 0 .. N/2-1
// st_drain | two read-free cycles so the stage's last writes land
// st_done  | one-cycle done pulse
module radix_2_ctrl #(
  parameter int width = 32,
  parameter int n_log = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic [n_log-1:0]   stage,
  output logic               bf_select,
  output logic               rd_en,
  output logic [n_log-1:0]   rd_addr_1,
  output logic [n_log-1:0]   rd_addr_2,
  output logic [n_log-1:0]   tw_idx,
  input  logic [width-1:0]   bf_out_1,
  input  logic [width-1:0]   bf_out_2,
  output logic               wr_en,
  output logic [n_log-1:0]   wr_addr_1,
  output logic [n_log-1:0]   wr_addr_2,
  output logic [width-1:0]   wr_data_1,
  output logic [width-1:0]   wr_data_2
);

  typedef enum logic [1:0] {st_idle, st_run, st_drain, st_done} state_t;

  localparam logic [n_log-1:0] one    = n_log'(1);
  localparam logic [n_log-1:0] last_s = n_log'(n_log - 1);
  localparam logic [n_log-1:0] p_last = n_log'((1 << (n_log - 1)) - 1);

  state_t            state, state_nxt;
  logic [n_log-1:0]  s, p;
  logic              mode_q;
  logic              drain_cnt;

  logic [n_log-1:0]  sh, len, j, g, idx1, tw;

  logic              v1;
  logic [n_log-1:0]  a1_1, a1_2;

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:  if (start) state_nxt = st_run;
      st_run:   if (p == p_last) state_nxt = st_drain;
      st_drain: if (drain_cnt == 1'b0) state_nxt = (s == last_s) ? st_done : st_run;
      st_done:  state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= st_idle;
      s         <= '0;
      p         <= '0;
      mode_q    <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        st_idle: begin
          if (start) begin
            mode_q <= mode;
            s      <= '0;
            p      <= '0;
          end
        end
        st_run: begin
          if (p == p_last) begin
            p         <= '0;
            drain_cnt <= 1'b1;
          end else begin
            p <= p + one;
          end
        end
        st_drain: begin
          if (drain_cnt != 1'b0) drain_cnt <= drain_cnt - 1'b1;
          else if (s != last_s) s <= s + one;
        end
        default: ;
      endcase
    end
  end

  // NTT and INTT share one addressing form; only the half-span exponent sh
  // differs (n_log-1-s for NTT, s for INTT). The twiddle base is then
  // 1 << (n_log-1-sh) in both cases, which keeps tw_idx non-zero.
  always_comb begin
    sh   = mode_q ? s : (last_s - s);
    len  = one << sh;
    j    = p & (len - one);
    g    = p >> sh;
    idx1 = (g << (sh + one)) | j;
    tw   = (one << (last_s - sh)) + g;
  end

  assign rd_en     = (state == st_run);
  assign busy      = (state == st_run) || (state == st_drain);
  assign done      = (state == st_done);
  assign stage     = s;
  assign bf_select = mode_q;
  assign rd_addr_1 = rd_en ? idx1 : '0;
  assign rd_addr_2 = rd_en ? (idx1 + len) : '0;
  assign tw_idx    = rd_en ? tw : '0;

  // Two-deep write pipeline: stage 1 covers the memory read latency, stage 2
  // captures the butterfly result alongside its addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      a1_1      <= '0;
      a1_2      <= '0;
      wr_en     <= 1'b0;
      wr_addr_1 <= '0;
      wr_addr_2 <= '0;
      wr_data_1 <= '0;
      wr_data_2 <= '0;
    end else begin
      v1        <= rd_en;
      a1_1      <= rd_addr_1;
      a1_2      <= rd_addr_2;
      wr_en     <= v1;
      wr_addr_1 <= a1_1;
      wr_addr_2 <= a1_2;
      if (v1) begin
        wr_data_1 <= bf_out_1;
        wr_data_2 <= bf_out_2;
      end
    end
  end

endmodule

// File: tb/tb_radix_2_ctrl.sv
// Bench for radix_2_ctrl at n_log = 3 (N = 8). Expected pair/twiddle lists
// come from the textbook nested-loop formulation of the transforms; the
// cycle schedule is derived from the run's cycle number. A memory stand-in
// returns 0x100+addr / 0x200+addr one cycle after each read.
module tb_radix_2_ctrl;
  localparam int width    = 32;
  localparam int n_log    = 3;
  localparam int nn       = 8;
  localparam int half     = 4;
  localparam int period   = half + 2;
  localparam int done_cyc = n_log * period + 1;
  localparam int npairs   = n_log * half;

  logic clk = 1'b0;
  logic rst_n, start, mode;
  logic busy, done, bf_select, rd_en, wr_en;
  logic [n_log-1:0] stage, rd_addr_1, rd_addr_2, tw_idx, wr_addr_1, wr_addr_2;
  logic [width-1:0] bf_out_1, bf_out_2, wr_data_1, wr_data_2;
  logic [n_log-1:0] mem_q1, mem_q2;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  int exp_a1 [2][npairs];
  int exp_a2 [2][npairs];
  int exp_tw [2][npairs];

  int   m_t;
  logic m_mode;

  radix_2_ctrl #(.width(width), .n_log(n_log)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .stage(stage), .bf_select(bf_select),
    .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .tw_idx(tw_idx),
    .bf_out_1(bf_out_1), .bf_out_2(bf_out_2),
    .wr_en(wr_en), .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2),
    .wr_data_1(wr_data_1), .wr_data_2(wr_data_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q1 <= '0;
      mem_q2 <= '0;
    end else begin
      mem_q1 <= rd_addr_1;
      mem_q2 <= rd_addr_2;
    end
  end
  assign bf_out_1 = 32'h100 + 32'(mem_q1);
  assign bf_out_2 = 32'h200 + 32'(mem_q2);

  initial begin
    for (int md = 0; md < 2; md++) begin
      automatic int n = 0;
      for (int s = 0; s < n_log; s++) begin
        automatic int ln = md ? (1 << s) : (nn >> (s + 1));
        for (int k = 0; k < nn; k += 2 * ln) begin
          for (int jj = 0; jj < ln; jj++) begin
            exp_a1[md][n] = k + jj;
            exp_a2[md][n] = k + jj + ln;
            exp_tw[md][n] = (md ? (nn >> (s + 1)) : (1 << s)) + k / (2 * ln);
            n++;
          end
        end
      end
    end
  end

  // Run-cycle model: m_t = cycle number within the current transform, 0 when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= 0;
      m_mode <= 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t    <= 1;
        m_mode <= mode;
      end
    end else if (m_t == done_cyc) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic bit rd_at(int t);
    return (t >= 1) && (t < done_cyc) && (((t - 1) % period) < half);
  endfunction

  function automatic int pair_of(int t);
    return ((t - 1) / period) * half + ((t - 1) % period);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    automatic bit e_rd = rd_at(m_t);
    automatic bit e_wr = (m_t >= 3) && rd_at(m_t - 2);
    automatic int md   = int'(m_mode);
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("busy", 32'(busy), 32'((m_t >= 1) && (m_t < done_cyc)));
    chk("done", 32'(done), 32'(m_t == done_cyc));
    if (m_t >= 1) chk("bf_select", 32'(bf_select), 32'(m_mode));
    if ((m_t >= 1) && (m_t < done_cyc)) chk("stage", 32'(stage), (m_t - 1) / period);
    if (e_rd) begin
      automatic int i = pair_of(m_t);
      chk("rd_addr_1", 32'(rd_addr_1), exp_a1[md][i]);
      chk("rd_addr_2", 32'(rd_addr_2), exp_a2[md][i]);
      chk("tw_idx", 32'(tw_idx), exp_tw[md][i]);
    end
    if (e_wr) begin
      automatic int i = pair_of(m_t - 2);
      chk("wr_addr_1", 32'(wr_addr_1), exp_a1[md][i]);
      chk("wr_addr_2", 32'(wr_addr_2), exp_a2[md][i]);
      chk("wr_data_1", wr_data_1, 32'h100 + exp_a1[md][i]);
      chk("wr_data_2", wr_data_2, 32'h200 + exp_a2[md][i]);
    end
  end

  task automatic start_run(input logic m);
    start = 1'b1;
    mode  = m;
    cur   = 0;
  endtask

  task automatic at_cycle(input int c);
    repeat (c - cur) @(posedge clk);
    @(negedge clk);
    cur = c;
  endtask

  task automatic spot_pair(input string nm, input int a1, input int a2, input int tw);
    chk({nm, "_a1"}, 32'(rd_addr_1), a1);
    chk({nm, "_a2"}, 32'(rd_addr_2), a2);
    chk({nm, "_tw"}, 32'(tw_idx), tw);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_stage", 32'(stage), 0);
    chk("rst_bf_select", 32'(bf_select), 0);
    chk("rst_rd_addr_1", 32'(rd_addr_1), 0);
    chk("rst_rd_addr_2", 32'(rd_addr_2), 0);
    chk("rst_tw_idx", 32'(tw_idx), 0);
    chk("rst_wr_addr_1", 32'(wr_addr_1), 0);
    chk("rst_wr_addr_2", 32'(wr_addr_2), 0);
    chk("rst_wr_data_1", wr_data_1, 0);
    chk("rst_wr_data_2", wr_data_2, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // NTT
    start_run(1'b0);
    at_cycle(1);  start = 1'b0; spot_pair("ntt_c1", 0, 4, 1);
    at_cycle(2);  chk("ntt_c2_wr_en", 32'(wr_en), 0);
    at_cycle(3);  chk("ntt_c3_wr_en", 32'(wr_en), 1);
                  chk("ntt_c3_wr_data_1", wr_data_1, 32'h100);
    at_cycle(8);  spot_pair("ntt_c8", 1, 3, 2);
    at_cycle(16); spot_pair("ntt_c16", 6, 7, 7);
    at_cycle(17); chk("ntt_c17_rd_en", 32'(rd_en), 0);
    at_cycle(19); chk("ntt_c19_done", 32'(done), 1);
                  chk("ntt_c19_busy", 32'(busy), 0);
    at_cycle(20);

    // INTT, started in the cycle right after done
    start_run(1'b1);
    at_cycle(1);  start = 1'b0; spot_pair("intt_c1", 0, 1, 4);
                  chk("intt_c1_bf_select", 32'(bf_select), 1);
    at_cycle(10); spot_pair("intt_c10", 5, 7, 3);
    at_cycle(13); spot_pair("intt_c13", 0, 4, 1);
    at_cycle(19); chk("intt_c19_done", 32'(done), 1);
    at_cycle(21);

    // NTT with a spurious start and mode toggling mid-run
    start_run(1'b0);
    at_cycle(1);  start = 1'b0;
    at_cycle(5);  start = 1'b1; mode = 1'b1;
    at_cycle(6);  start = 1'b0; mode = 1'b0;
    at_cycle(9);  mode = 1'b1;
    at_cycle(13); spot_pair("tog_c13", 0, 1, 4);
                  chk("tog_c13_bf_select", 32'(bf_select), 0);
    at_cycle(19); chk("tog_c19_done", 32'(done), 1);
    at_cycle(21);

    // Reset in the middle of a run, then restart from scratch
    start_run(1'b0);
    at_cycle(1);  start = 1'b0;
    at_cycle(8);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_run(1'b0);
    at_cycle(1);  start = 1'b0; spot_pair("restart_c1", 0, 4, 1);
                  chk("restart_c1_stage", 32'(stage), 0);
    at_cycle(19); chk("restart_c19_done", 32'(done), 1);
    at_cycle(22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
